// File: rtl/prize_pkg.sv
// Shared types and constants for the Bumpy prize manager and the prize drawing objects.
package prize_pkg;

  typedef enum logic [2:0] {
    FREE = 3'b000,
    REGU = 3'b001
  } prize_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } pm_state_t;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS            = 8'hB8;
  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/prize_lfsr.sv
// Free-running 8-bit Galois LFSR used to seed prize colours.
module prize_lfsr
  import prize_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       resetN,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) value <= SEED;
    else         value <= lfsr_step(value);
  end

endmodule

// File: rtl/prize_manager.sv
// Per-tile prize state: layout load, collect handshake, colour rotation and draw lookup.
module prize_manager
  import prize_pkg::*;
#(
  parameter int         NUM_TILES    = 16,
  parameter int         COLOR_PERIOD = 30,
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  localparam int        IW           = $clog2(NUM_TILES),
  localparam int        CW           = IW + 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 level_start,
  input  logic [NUM_TILES-1:0] level_map,
  input  logic [IW-1:0]        draw_tile_idx,
  input  logic                 collect_req,
  input  logic [IW-1:0]        collect_idx,
  output logic                 collect_ack,
  output logic                 score_pulse,
  output logic [2:0]           prize_type,
  output logic [1:0]           random_prize_color,
  output logic [CW-1:0]        prizes_left,
  output logic                 level_done
);

  localparam int FW = $clog2(COLOR_PERIOD + 1);

  pm_state_t                  state;
  logic [IW-1:0]              ptr;
  logic [NUM_TILES-1:0]       active;
  logic [NUM_TILES-1:0][1:0]  color;
  logic [FW-1:0]              frame_cnt;
  logic                       pending;
  logic [IW-1:0]              pend_idx;
  logic                       req_seen;
  logic [7:0]                 lfsr;
  logic [CW-1:0]              load_cnt;
  logic                       lfsr_unused;

  prize_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .resetN(resetN),
    .value (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:2];
  assign load_cnt    = prizes_left + CW'(level_map[ptr]);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      ptr         <= '0;
      active      <= '0;
      color       <= '0;
      frame_cnt   <= '0;
      pending     <= 1'b0;
      pend_idx    <= '0;
      req_seen    <= 1'b0;
      collect_ack <= 1'b0;
      score_pulse <= 1'b0;
      prizes_left <= '0;
      level_done  <= 1'b0;
    end else begin
      collect_ack <= 1'b0;
      score_pulse <= 1'b0;
      if (!collect_req) req_seen <= 1'b0;
      // A held request is dropped on reload; req_seen keeps it from re-firing
      if (level_start) begin
        state       <= LOAD;
        ptr         <= '0;
        active      <= '0;
        prizes_left <= '0;
        frame_cnt   <= '0;
        pending     <= 1'b0;
        level_done  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            active[ptr] <= level_map[ptr];
            color[ptr]  <= lfsr[1:0];
            prizes_left <= load_cnt;
            ptr         <= ptr + IW'(1);
            if (ptr == IW'(NUM_TILES - 1)) begin
              state      <= (load_cnt != '0) ? RUN : DONE;
              level_done <= (load_cnt == '0);
            end
          end
          RUN: begin
            if (prizes_left == '0) begin
              state      <= DONE;
              level_done <= 1'b1;
              pending    <= 1'b0;
            end else if (pending) begin
              pending     <= 1'b0;
              collect_ack <= 1'b1;
              if (active[pend_idx]) begin
                active[pend_idx] <= 1'b0;
                score_pulse      <= 1'b1;
                prizes_left      <= prizes_left - CW'(1);
              end
            end else if (collect_req && !req_seen) begin
              pending  <= 1'b1;
              pend_idx <= collect_idx;
              req_seen <= 1'b1;
            end
            // Rotation touches every tile, active or not
            if (startOfFrame) begin
              if (frame_cnt == FW'(COLOR_PERIOD - 1)) begin
                frame_cnt <= '0;
                for (int i = 0; i < NUM_TILES; i++) color[i] <= color[i] + 2'd1;
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
          DONE: level_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prize_type         <= FREE;
      random_prize_color <= 2'd0;
    end else begin
      prize_type         <= active[draw_tile_idx] ? REGU : FREE;
      random_prize_color <= color[draw_tile_idx];
    end
  end

endmodule

// File: tb/tb_prize_manager.sv
// Directed scoreboard bench for prize_manager (16 tiles, colour period 2).
module tb_prize_manager;

  localparam int N = 16;

  typedef struct {
    logic [2:0] ty;
    logic [1:0] col;
  } draw_exp_t;

  typedef struct {
    logic       sc;
    logic [4:0] left;
  } col_exp_t;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        level_start = 1'b0;
  logic        collect_req = 1'b0;
  logic [15:0] level_map = '0;
  logic [3:0]  draw_tile_idx = '0;
  logic [3:0]  collect_idx = '0;
  logic        collect_ack, score_pulse, level_done;
  logic [2:0]  prize_type;
  logic [1:0]  random_prize_color;
  logic [4:0]  prizes_left;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  m_lfsr;
  logic [1:0]  pcol [N];
  draw_exp_t   draw_q[$];
  col_exp_t    col_q[$];

  always #5 clk = ~clk;

  prize_manager #(.NUM_TILES(16), .COLOR_PERIOD(2), .LFSR_SEED(8'hA5)) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .level_start       (level_start),
    .level_map         (level_map),
    .draw_tile_idx     (draw_tile_idx),
    .collect_req       (collect_req),
    .collect_idx       (collect_idx),
    .collect_ack       (collect_ack),
    .score_pulse       (score_pulse),
    .prize_type        (prize_type),
    .random_prize_color(random_prize_color),
    .prizes_left       (prizes_left),
    .level_done        (level_done)
  );

  // Reference LFSR written out bit by bit from the polynomial
  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[0], v[7], v[6] ^ v[0], v[5] ^ v[0], v[4] ^ v[0], v[3], v[2], v[1]};
  endfunction

  always @(posedge clk or negedge resetN)
    if (!resetN) m_lfsr <= 8'hA5;
    else         m_lfsr <= nxt(m_lfsr);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_level(input logic [15:0] map, output int acks);
    logic [7:0] v;
    v = m_lfsr;
    for (int p = 0; p < N; p++) begin
      v = nxt(v);
      pcol[p] = v[1:0];
    end
    level_map = map;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    acks = collect_ack ? 1 : 0;
    for (int c = 0; c < N; c++) begin
      tick();
      if (collect_ack) acks++;
    end
  endtask

  task automatic draw_check(input logic [3:0] idx, input logic [2:0] ty, input logic [1:0] col);
    draw_exp_t e;
    draw_q.push_back('{ty, col});
    draw_tile_idx = idx;
    tick();
    e = draw_q.pop_front();
    chk("draw_type", 32'(prize_type), 32'(e.ty));
    chk("draw_color", 32'(random_prize_color), 32'(e.col));
  endtask

  task automatic collect(input logic [3:0] idx, input logic sc, input logic [4:0] left, input int hold);
    col_exp_t e;
    int lat;
    col_q.push_back('{sc, left});
    collect_idx = idx;
    collect_req = 1'b1;
    lat = 0;
    while (!collect_ack && lat < 8) begin
      tick();
      lat++;
    end
    e = col_q.pop_front();
    chk("ack_seen", 32'(collect_ack), 1);
    chk("ack_latency", lat, 2);
    chk("score", 32'(score_pulse), 32'(e.sc));
    chk("left", 32'(prizes_left), 32'(e.left));
    chk("done_at_ack", 32'(level_done), 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("held_no_ack", 32'(collect_ack), 0);
      chk("held_no_score", 32'(score_pulse), 0);
    end
    collect_req = 1'b0;
    tick();
    chk("ack_one_cycle", 32'(collect_ack), 0);
    chk("score_one_cycle", 32'(score_pulse), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int waitc;
    logic [7:0] t;

    repeat (2) tick();
    chk("rst_type", 32'(prize_type), 0);
    chk("rst_color", 32'(random_prize_color), 0);
    chk("rst_ack", 32'(collect_ack), 0);
    chk("rst_score", 32'(score_pulse), 0);
    chk("rst_done", 32'(level_done), 0);
    chk("rst_left", 32'(prizes_left), 0);
    resetN = 1'b1;
    tick();

    // Level with tiles 0 and 2
    start_level(16'h0005, acks);
    chk("load1_no_ack", acks, 0);
    chk("load1_left", 32'(prizes_left), 2);
    chk("load1_done", 32'(level_done), 0);
    draw_check(4'd2, 3'b001, pcol[2]);
    draw_check(4'd1, 3'b000, pcol[1]);
    draw_check(4'd0, 3'b001, pcol[0]);
    collect(4'd0, 1'b1, 5'd1, 3);
    collect(4'd0, 1'b0, 5'd1, 0);
    draw_check(4'd0, 3'b000, pcol[0]);
    collect(4'd2, 1'b1, 5'd0, 0);
    chk("done_after_last", 32'(level_done), 1);

    // Requests in DONE are ignored
    collect_idx = 4'd1;
    collect_req = 1'b1;
    acks = 0;
    repeat (4) begin
      tick();
      if (collect_ack) acks++;
    end
    collect_req = 1'b0;
    chk("done_no_ack", acks, 0);
    chk("done_hold", 32'(level_done), 1);

    // Empty layout goes straight to DONE
    level_map = 16'h0000;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    chk("restart_clears_done", 32'(level_done), 0);
    for (int c = 1; c <= N; c++) begin
      tick();
      if (c == N - 1) chk("empty_done_early", 32'(level_done), 0);
    end
    chk("empty_done", 32'(level_done), 1);
    chk("empty_left", 32'(prizes_left), 0);

    // Time the load so tile 0 picks up colour 3
    waitc = 0;
    t = nxt(m_lfsr);
    while (t[1:0] != 2'b11 && waitc < 300) begin
      tick();
      waitc++;
      t = nxt(m_lfsr);
    end
    start_level(16'h0003, acks);
    draw_check(4'd0, 3'b001, 2'b11);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    draw_check(4'd0, 3'b001, 2'b11);
    draw_tile_idx = 4'd0;
    collect_idx = 4'd0;
    collect_req = 1'b1;
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("rot_ack", 32'(collect_ack), 1);
    chk("rot_score", 32'(score_pulse), 1);
    chk("rot_left", 32'(prizes_left), 1);
    chk("rot_type_pre", 32'(prize_type), 1);
    chk("rot_color_pre", 32'(random_prize_color), 3);
    collect_req = 1'b0;
    tick();
    chk("rot_type_post", 32'(prize_type), 0);
    chk("rot_color_wrap", 32'(random_prize_color), 0);
    draw_check(4'd1, 3'b001, pcol[1] + 2'd1);

    // level_start while a collect is pending
    collect_idx = 4'd1;
    collect_req = 1'b1;
    tick();
    collect_req = 1'b0;
    start_level(16'h0001, acks);
    chk("abort_no_ack", acks, 0);
    chk("abort_left", 32'(prizes_left), 1);
    draw_check(4'd1, 3'b000, pcol[1]);
    collect(4'd0, 1'b1, 5'd0, 0);
    chk("abort_done", 32'(level_done), 1);

    // Reset in the middle of LOAD (tile 7 next)
    level_map = 16'hFFFF;
    draw_tile_idx = 4'd0;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    repeat (7) tick();
    chk("midload_left", 32'(prizes_left), 7);
    chk("midload_type", 32'(prize_type), 1);
    resetN = 1'b0;
    #1;
    chk("rst2_type", 32'(prize_type), 0);
    chk("rst2_color", 32'(random_prize_color), 0);
    chk("rst2_left", 32'(prizes_left), 0);
    chk("rst2_ack", 32'(collect_ack), 0);
    chk("rst2_score", 32'(score_pulse), 0);
    chk("rst2_done", 32'(level_done), 0);
    tick();
    tick();
    resetN = 1'b1;
    tick();
    chk("post_rst_left", 32'(prizes_left), 0);
    chk("post_rst_done", 32'(level_done), 0);
    start_level(16'h8001, acks);
    chk("reload_left", 32'(prizes_left), 2);
    draw_check(4'd0, 3'b001, pcol[0]);
    draw_check(4'd15, 3'b001, pcol[15]);
    draw_check(4'd7, 3'b000, pcol[7]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prize_manager.md
# prize_manager

Owns the per-tile prize state for the Bumpy playfield and sequences the regular-prize drawing objects. It loads the prize layout at level start and assigns each prize a pseudo-random colour. During play it serves collect requests from collision logic, rotates prize colours on a frame cadence, and reports score and level completion. It sits between the collision/game-control logic and the per-tile prize drawing objects, and supplies their `prize_type` and `random_prize_color` inputs.

## Interface
- `NUM_TILES`, 16: number of grid tiles. Must be a power of two, ≤ 32.
- `COLOR_PERIOD`, 30: frames between colour rotations. Must be ≥ 1.
- `LFSR_SEED`, 8'hA5: LFSR reset value. Must be non-zero.
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per VGA frame.
- `level_start` in 1: one-cycle pulse that (re)loads the layout.
- `level_map` in NUM_TILES: bit i = 1 means tile i starts with a regular prize. Sampled during LOAD.
- `draw_tile_idx` in log2(NUM_TILES): tile currently being rendered.
- `collect_req` in 1: collision request. Held high until ack.
- `collect_idx` in log2(NUM_TILES): tile being collected. Stable while `collect_req` is high.
- `collect_ack` out 1: one-cycle acknowledge.
- `score_pulse` out 1: one-cycle pulse, one per prize actually collected.
- `prize_type` out 3: type of `draw_tile_idx` (FREE=3'b000, REGU=3'b001).
- `random_prize_color` out 2: colour index of `draw_tile_idx`.
- `prizes_left` out log2(NUM_TILES)+1: number of active prizes.
- `level_done` out 1: high while in DONE.

## Operation
- Per-tile storage:
  - `active[i]`, 1 bit.
  - `color[i]`, 2 bits.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Waits for `level_start`.
  - Outputs show FREE for every tile.
- LOAD:
  - Tile pointer p runs 0 to NUM_TILES-1, one tile per cycle.
  - Each cycle: `active[p]` ← `level_map[p]` and `color[p]` ← LFSR[1:0].
  - The counter accumulates the number of set bits.
  - After tile NUM_TILES-1: go to RUN if the count > 0, else DONE.
- RUN:
  - On `collect_req` with no ack pending, raise `collect_ack` on the next cycle.
  - If `active[collect_idx]` is set: clear it, assert `score_pulse` in the same cycle as the ack, and decrement `prizes_left`.
  - If the tile is already inactive: ack with no score.
  - A request still high on the cycle after the ack is a new request only once it has dropped and risen again. Ack is edge-qualified by an internal `req_seen` flag that clears when `collect_req` goes low.
  - When `prizes_left` reaches 0: go to DONE.
- DONE: holds `level_done` = 1; exits only on `level_start`.
- `level_start` in any state goes to LOAD with p = 0 and clears all `active` bits. An outstanding collect is dropped with no ack.
- Collect requests in IDLE, LOAD or DONE are not acked.
- Colour rotation:
  - A frame counter counts `startOfFrame` pulses in RUN only.
  - On reaching COLOR_PERIOD it wraps to 0, and every `color[i]` increments mod 4 (2'b11 wraps to 2'b00), including inactive tiles.
- Collect and rotation in the same cycle: both apply; the collected tile is cleared regardless.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Steps every cycle, including in IDLE.
- Draw lookup: `prize_type` = REGU if `active[draw_tile_idx]`, else FREE. `random_prize_color` = `color[draw_tile_idx]`.

## Timing
- Reset values:
  - State: IDLE.
  - LFSR: LFSR_SEED.
  - `active`: all 0. `color`: all 0.
  - Frame counter: 0.
  - `collect_ack`, `score_pulse`, `level_done`: 0.
  - `prizes_left`: 0.
  - `prize_type`: FREE. `random_prize_color`: 0.
- Reset is honoured mid-LOAD and mid-handshake with no residual pulse.
- Draw lookup latency: 1 cycle. Outputs are registered from `draw_tile_idx` and reflect storage as of the previous edge.
- LOAD duration: exactly NUM_TILES cycles after the `level_start` cycle. RUN or DONE is entered on cycle NUM_TILES+1.
- Collect latency: request sampled at edge k; `collect_ack`, `score_pulse` and the `prizes_left` update are all visible after edge k+1.
- `level_done` rises one cycle after the final collect's ack.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- `prize_pkg` contains:
  - `prize_t` enum: FREE = 3'b000, REGU = 3'b001.
  - `pm_state_t` enum: IDLE, LOAD, RUN, DONE.
  - LFSR tap mask constant.
  - TRANSPARENT_ENCODING = 8'hFF, shared with the drawing objects.
- Sub-module `prize_lfsr`:
  - Ports: `clk`, `resetN`, seed parameter, 8-bit `value` output.
  - Free-running.
- All other logic lives in `prize_manager`.

## Test plan
- Reset, then `level_start` with `level_map` = 16'h0005 → after 16 LOAD cycles, state is RUN, `prizes_left` = 2, and `draw_tile_idx` = 2 gives `prize_type` 3'b001 one cycle later.
- Collect tile 0 → `collect_ack` and `score_pulse` high for 1 cycle, `prizes_left` = 1. Collect tile 0 again → ack only, no score, count still 1.
- Collect tile 2 → `prizes_left` = 0, and `level_done` = 1 on the following cycle.
- `level_map` = 0 → DONE after 16 LOAD cycles with no RUN cycle.
- COLOR_PERIOD = 2 with `color[0]` = 2'b11 → after 2 `startOfFrame` pulses in RUN, `color[0]` = 2'b00. A collect on that same cycle still clears the tile.
- Two mid-operation aborts:
  - `resetN` low mid-LOAD (p = 7) → all outputs at reset values; the next `level_start` reloads from tile 0.
  - `level_start` during a pending collect → no ack, LOAD restarts.
